boot_loader: RTL and testbench

Boot sequencer between the instruction ROM, the data RAM and `top_core`. After reset it owns both memory ports and copies the initialised-data image from ROM to RAM while holding the core in reset. When the copy is complete it hands the ROM address port and the RAM write port to the core and releases the core reset. A soft reboot request repeats the whole sequence.

---
 rtl/boot_loader_if.sv | 42 ++++
 rtl/boot_loader.sv | 118 +++++++++++
 tb/tb_boot_loader.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_if.sv
// Memory/core bus bundle for boot_loader: ROM fetch port, RAM write port and core-side requests.
// The master modport is the boot sequencer; the slave modport is the memory/core side.
interface boot_loader_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned AWIDTH = 16
);
    logic [AWIDTH-1:0] core_inst_addr;
    logic [AWIDTH-1:0] core_dmem_addr;
    logic [XLEN-1:0]   core_dmem_wdata;
    logic [3:0]        core_dmem_we;

    logic [AWIDTH-1:0] rom_addr;
    logic [XLEN-1:0]   rom_data;

    logic [AWIDTH-1:0] ram_addr;
    logic [XLEN-1:0]   ram_wdata;
    logic [3:0]        ram_we;

    modport master (
        input  core_inst_addr,
        input  core_dmem_addr,
        input  core_dmem_wdata,
        input  core_dmem_we,
        input  rom_data,
        output rom_addr,
        output ram_addr,
        output ram_wdata,
        output ram_we
    );

    modport slave (
        output core_inst_addr,
        output core_dmem_addr,
        output core_dmem_wdata,
        output core_dmem_we,
        output rom_data,
        input  rom_addr,
        input  ram_addr,
        input  ram_wdata,
        input  ram_we
    );
endinterface

// File: rtl/boot_loader.sv
// Boot sequencer: copies the initialised-data image from ROM to RAM with the core held in reset,
// then hands both memory ports to the core. A reboot request in RUN repeats the sequence.
module boot_loader #(
    parameter int unsigned       XLEN     = 32,
    parameter int unsigned       AWIDTH   = 16,
    parameter logic [AWIDTH-1:0] SRC_BASE = 'h800,
    parameter logic [AWIDTH-1:0] DST_BASE = 'h0,
    parameter int unsigned       WORDS    = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reboot,
    boot_loader_if.master   bus,
    output logic            core_rst_n,
    output logic            boot_done,
    output logic [XLEN-1:0] boot_csum
);

    // Index counters must be able to hold WORDS itself (rd_idx saturates there).
    localparam int unsigned     IDXW     = (WORDS < 2) ? 1 : $clog2(WORDS + 1);
    localparam logic [IDXW-1:0] LAST_IDX = (WORDS == 0) ? '0 : IDXW'(WORDS - 1);
    localparam logic [IDXW-1:0] MAX_IDX  = IDXW'(WORDS);

    typedef enum logic [1:0] {
        StFill,
        StCopy,
        StRelease,
        StRun
    } state_e;

    state_e            state;
    logic [IDXW-1:0]   rd_idx;
    logic [IDXW-1:0]   wr_idx;
    logic [XLEN-1:0]   csum;
    logic [AWIDTH-1:0] rd_addr;
    logic [AWIDTH-1:0] wr_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StFill;
            rd_idx     <= '0;
            wr_idx     <= '0;
            csum       <= '0;
            core_rst_n <= 1'b0;
            boot_done  <= 1'b0;
        end else begin
            case (state)
                StFill: begin
                    if (WORDS == 0) begin
                        state <= StRelease;
                    end else begin
                        state  <= StCopy;
                        rd_idx <= IDXW'(1);
                    end
                end
                StCopy: begin
                    wr_idx <= wr_idx + 1'b1;
                    csum   <= csum + bus.rom_data;
                    if (rd_idx != MAX_IDX) begin
                        rd_idx <= rd_idx + 1'b1;
                    end
                    if (wr_idx == LAST_IDX) begin
                        state <= StRelease;
                    end
                end
                StRelease: begin
                    state      <= StRun;
                    core_rst_n <= 1'b1;
                    boot_done  <= 1'b1;
                end
                StRun: begin
                    if (reboot) begin
                        state      <= StFill;
                        rd_idx     <= '0;
                        wr_idx     <= '0;
                        csum       <= '0;
                        core_rst_n <= 1'b0;
                        boot_done  <= 1'b0;
                    end
                end
                default: state <= StFill;
            endcase
        end
    end

    // Word index to byte address; arithmetic wraps at AWIDTH bits.
    assign rd_addr = SRC_BASE + (AWIDTH'(rd_idx) << 2);
    assign wr_addr = DST_BASE + (AWIDTH'(wr_idx) << 2);

    // Mux select depends on registered state only; the RUN path is combinational pass-through.
    always_comb begin
        bus.rom_addr  = SRC_BASE;
        bus.ram_addr  = DST_BASE;
        bus.ram_wdata = bus.rom_data;
        bus.ram_we    = 4'h0;
        case (state)
            StCopy: begin
                bus.rom_addr = rd_addr;
                bus.ram_addr = wr_addr;
                bus.ram_we   = 4'hF;
            end
            StRelease: begin
                bus.rom_addr = rd_addr;
                bus.ram_addr = wr_addr;
            end
            StRun: begin
                bus.rom_addr  = bus.core_inst_addr;
                bus.ram_addr  = bus.core_dmem_addr;
                bus.ram_wdata = bus.core_dmem_wdata;
                bus.ram_we    = bus.core_dmem_we;
            end
            default: ;
        endcase
    end

    assign boot_csum = csum;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: nominal 4-word copy, pass-through, reboot, reset mid-copy,
// checksum wrap (2 words) and empty image (0 words), each on its own instance.
module tb_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic reboot_a = 1'b0, reboot_b = 1'b0, reboot_c = 1'b0;
    logic crn_a, crn_b, crn_c;
    logic done_a, done_b, done_c;
    logic [31:0] csum_a, csum_b, csum_c;

    int nvec = 0;
    int nmis = 0;

    logic [31:0] img [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    boot_loader_if #(.XLEN(32), .AWIDTH(16)) bus_a ();
    boot_loader_if #(.XLEN(32), .AWIDTH(16)) bus_b ();
    boot_loader_if #(.XLEN(32), .AWIDTH(16)) bus_c ();

    boot_loader #(.XLEN(32), .AWIDTH(16), .SRC_BASE(16'h0800), .DST_BASE(16'h0000), .WORDS(4))
    dut_a (.clk(clk), .rst(rst_a), .reboot(reboot_a), .bus(bus_a.master),
           .core_rst_n(crn_a), .boot_done(done_a), .boot_csum(csum_a));

    boot_loader #(.XLEN(32), .AWIDTH(16), .SRC_BASE(16'h0800), .DST_BASE(16'h0000), .WORDS(2))
    dut_b (.clk(clk), .rst(rst_b), .reboot(reboot_b), .bus(bus_b.master),
           .core_rst_n(crn_b), .boot_done(done_b), .boot_csum(csum_b));

    boot_loader #(.XLEN(32), .AWIDTH(16), .SRC_BASE(16'h0800), .DST_BASE(16'h0000), .WORDS(0))
    dut_c (.clk(clk), .rst(rst_c), .reboot(reboot_c), .bus(bus_c.master),
           .core_rst_n(crn_c), .boot_done(done_c), .boot_csum(csum_c));

    function automatic logic [31:0] rom_a_f(input logic [15:0] a);
        case (a)
            16'h0800: return 32'h11111111;
            16'h0804: return 32'h22222222;
            16'h0808: return 32'h33333333;
            16'h080C: return 32'h44444444;
            default:  return {16'hDEAD, a};
        endcase
    endfunction

    function automatic logic [31:0] rom_b_f(input logic [15:0] a);
        case (a)
            16'h0800: return 32'hFFFFFFFF;
            16'h0804: return 32'h00000002;
            default:  return {16'hDEAD, a};
        endcase
    endfunction

    // Synchronous ROMs: address sampled at the edge, data valid the following cycle.
    always @(posedge clk) begin
        bus_a.rom_data <= rom_a_f(bus_a.rom_addr);
        bus_b.rom_data <= rom_b_f(bus_b.rom_addr);
        bus_c.rom_data <= {16'hDEAD, bus_c.rom_addr};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic copy_a(input string tag);
        for (int k = 0; k < 4; k++) begin
            step();
            chk({tag, "_addr"}, {16'h0, bus_a.ram_addr}, 32'(4 * k));
            chk({tag, "_wdata"}, bus_a.ram_wdata, img[k]);
            chk({tag, "_we"}, {28'h0, bus_a.ram_we}, 32'hF);
            chk({tag, "_done"}, {31'h0, done_a}, 32'h0);
            if (k == 2) reboot_a = 1'b0;
        end
        step();
        chk({tag, "_rel_we"}, {28'h0, bus_a.ram_we}, 32'h0);
        chk({tag, "_rel_done"}, {31'h0, done_a}, 32'h0);
        chk({tag, "_rel_crn"}, {31'h0, crn_a}, 32'h0);
        step();
        chk({tag, "_run_done"}, {31'h0, done_a}, 32'h1);
        chk({tag, "_run_crn"}, {31'h0, crn_a}, 32'h1);
        chk({tag, "_csum"}, csum_a, 32'hAAAAAAAA);
    endtask

    initial begin
        bus_a.core_inst_addr = '0; bus_a.core_dmem_addr = '0;
        bus_a.core_dmem_wdata = '0; bus_a.core_dmem_we = '0;
        bus_b.core_inst_addr = '0; bus_b.core_dmem_addr = '0;
        bus_b.core_dmem_wdata = '0; bus_b.core_dmem_we = '0;
        bus_c.core_inst_addr = '0; bus_c.core_dmem_addr = '0;
        bus_c.core_dmem_wdata = '0; bus_c.core_dmem_we = '0;

        repeat (2) step();
        chk("rst_rom_addr", {16'h0, bus_a.rom_addr}, 32'h800);
        chk("rst_ram_we", {28'h0, bus_a.ram_we}, 32'h0);
        chk("rst_crn", {31'h0, crn_a}, 32'h0);
        chk("rst_done", {31'h0, done_a}, 32'h0);
        chk("rst_csum", csum_a, 32'h0);

        // Nominal copy; rom_addr has advanced to word 1 in the first COPY cycle.
        rst_a = 1'b0;
        step();
        chk("e0_rom_addr", {16'h0, bus_a.rom_addr}, 32'h804);
        chk("e0_wdata", bus_a.ram_wdata, 32'h11111111);
        @(negedge clk);
        reset_a_to_fill();
        copy_a("nom");

        // Pass-through in RUN, same cycle.
        bus_a.core_inst_addr = 16'h0124; bus_a.core_dmem_addr = 16'h0040;
        bus_a.core_dmem_we = 4'b0011; bus_a.core_dmem_wdata = 32'hDEADBEEF;
        #1;
        chk("pt_rom_addr", {16'h0, bus_a.rom_addr}, 32'h124);
        chk("pt_ram_addr", {16'h0, bus_a.ram_addr}, 32'h40);
        chk("pt_ram_we", {28'h0, bus_a.ram_we}, 32'h3);
        chk("pt_ram_wdata", bus_a.ram_wdata, 32'hDEADBEEF);
        bus_a.core_inst_addr = 16'hFFFC; bus_a.core_dmem_addr = 16'h1230;
        bus_a.core_dmem_we = 4'b1100; bus_a.core_dmem_wdata = 32'h01234567;
        #1;
        chk("pt2_rom_addr", {16'h0, bus_a.rom_addr}, 32'hFFFC);
        chk("pt2_ram_addr", {16'h0, bus_a.ram_addr}, 32'h1230);
        chk("pt2_ram_we", {28'h0, bus_a.ram_we}, 32'hC);
        chk("pt2_ram_wdata", bus_a.ram_wdata, 32'h01234567);
        step();
        chk("run_csum_stable", csum_a, 32'hAAAAAAAA);
        chk("run_done_stable", {31'h0, done_a}, 32'h1);

        // Reboot pulse; reboot stays high into COPY and must be ignored there.
        reboot_a = 1'b1;
        step();
        chk("rb_crn", {31'h0, crn_a}, 32'h0);
        chk("rb_done", {31'h0, done_a}, 32'h0);
        chk("rb_csum", csum_a, 32'h0);
        chk("rb_rom_addr", {16'h0, bus_a.rom_addr}, 32'h800);
        chk("rb_ram_we", {28'h0, bus_a.ram_we}, 32'h0);
        copy_a("rbt");

        // Reset in the middle of the copy.
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        repeat (3) step();
        chk("mid_addr", {16'h0, bus_a.ram_addr}, 32'h8);
        chk("mid_we", {28'h0, bus_a.ram_we}, 32'hF);
        rst_a = 1'b1;
        #1;
        chk("mid_rst_we", {28'h0, bus_a.ram_we}, 32'h0);
        chk("mid_rst_crn", {31'h0, crn_a}, 32'h0);
        chk("mid_rst_rom_addr", {16'h0, bus_a.rom_addr}, 32'h800);
        @(negedge clk);
        rst_a = 1'b0;
        copy_a("mid");

        // Checksum wrap with two words.
        rst_b = 1'b0;
        step();
        chk("b_w0_addr", {16'h0, bus_b.ram_addr}, 32'h0);
        chk("b_w0_data", bus_b.ram_wdata, 32'hFFFFFFFF);
        step();
        chk("b_w1_addr", {16'h0, bus_b.ram_addr}, 32'h4);
        chk("b_w1_data", bus_b.ram_wdata, 32'h00000002);
        step();
        chk("b_rel_done", {31'h0, done_b}, 32'h0);
        chk("b_rel_we", {28'h0, bus_b.ram_we}, 32'h0);
        step();
        chk("b_done", {31'h0, done_b}, 32'h1);
        chk("b_csum", csum_b, 32'h00000001);

        // Empty image: RELEASE straight after E0, done at E1.
        rst_c = 1'b0;
        step();
        chk("c_e0_we", {28'h0, bus_c.ram_we}, 32'h0);
        chk("c_e0_done", {31'h0, done_c}, 32'h0);
        step();
        chk("c_done", {31'h0, done_c}, 32'h1);
        chk("c_crn", {31'h0, crn_c}, 32'h1);
        chk("c_csum", csum_c, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    // First nominal pass: E0 already taken above, so rewind to FILL for a clean full copy.
    task automatic reset_a_to_fill();
        rst_a = 1'b1;
        #1;
        chk("pre_fill_rom_addr", {16'h0, bus_a.rom_addr}, 32'h800);
        @(negedge clk);
        rst_a = 1'b0;
    endtask

endmodule
